// File: rtl/reg_wb_queue_pkg.sv
// rtl/reg_wb_queue_pkg.sv - shared widths and writeback entry type for the register-file write queue
package reg_wb_queue_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_wb_queue_if.sv
// rtl/reg_wb_queue_if.sv - valid/ready writeback handshake from the pipeline into the queue
interface reg_wb_queue_if;
  import reg_wb_queue_pkg::*;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  modport master (output wb_valid, output wb_addr, output wb_data, input  wb_ready);
  modport slave  (input  wb_valid, input  wb_addr, input  wb_data, output wb_ready);

endinterface

// File: rtl/reg_wb_queue_fifo.sv
// rtl/reg_wb_queue_fifo.sv - circular entry store with head/tail pointers and occupancy count
module reg_wb_queue_fifo
  import reg_wb_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  wb_entry_t               push_entry_i,
  input  logic                    pop_i,
  output wb_entry_t [DEPTH-1:0]   mem_o,
  output logic      [PTR_W-1:0]   head_o,
  output logic      [CNT_W-1:0]   count_o
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic do_push, do_pop;

  // Guards keep count inside 0..DEPTH even if the caller misbehaves.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_push = push_i && (count_q != CNT_W'(DEPTH));
    do_pop  = pop_i && (count_q != '0);
    if (do_push) begin
      mem_d[tail_q] = push_entry_i;
      tail_d        = tail_q + 1'b1;
    end
    if (do_pop) begin
      head_d = head_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      mem_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign mem_o   = mem_q;
  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/reg_wb_queue.sv
// rtl/reg_wb_queue.sv - buffers writeback results, drains one per clock to the register file,
// and forwards the newest pending value to the two decode read ports
module reg_wb_queue
  import reg_wb_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_n,
  reg_wb_queue_if.slave     wb,
  input  logic              hold_i,
  output logic              RegWrite_o,
  output logic [ADDR_W-1:0] RDaddr_o,
  output logic [DATA_W-1:0] RDdata_o,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  output logic              RS_hit_o,
  output logic [DATA_W-1:0] RSdata_o,
  output logic              RT_hit_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [CNT_W-1:0]  count_o
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0] head;
  logic [CNT_W-1:0] count;
  logic push, pop;
  wb_entry_t push_entry;

  wb_entry_t out_q, out_d;
  logic      we_q, we_d;

  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0]             rd_hit;
  logic [1:0][DATA_W-1:0] rd_data;
  logic [PTR_W-1:0]       idx;

  assign wb.wb_ready = (count < CNT_W'(DEPTH));

  // Writes to R0 complete the handshake but are dropped here.
  always_comb begin
    push_entry.addr = wb.wb_addr;
    push_entry.data = wb.wb_data;
    push = wb.wb_valid && wb.wb_ready && (wb.wb_addr != REG_ZERO);
    pop  = (count != '0) && !hold_i;
  end

  reg_wb_queue_fifo #(.DEPTH(DEPTH)) u_wb_fifo (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (pop),
    .mem_o       (mem),
    .head_o      (head),
    .count_o     (count)
  );

  always_comb begin
    we_d  = pop;
    out_d = pop ? mem[head] : out_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      we_q  <= 1'b0;
      out_q <= '0;
    end else begin
      we_q  <= we_d;
      out_q <= out_d;
    end
  end

  // Walk oldest to youngest so later matches override earlier ones.
  always_comb begin
    rd_addr[0] = RSaddr_i;
    rd_addr[1] = RTaddr_i;
    rd_hit     = '0;
    rd_data    = '0;
    idx        = '0;
    for (int p = 0; p < 2; p++) begin
      rd_hit[p]  = we_q && (out_q.addr == rd_addr[p]);
      rd_data[p] = out_q.data;
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PTR_W'(i);
        if ((CNT_W'(i) < count) && (mem[idx].addr == rd_addr[p])) begin
          rd_hit[p]  = 1'b1;
          rd_data[p] = mem[idx].data;
        end
      end
      if (rd_addr[p] == REG_ZERO) begin
        rd_hit[p] = 1'b0;
      end
    end
  end

  assign RegWrite_o = we_q;
  assign RDaddr_o   = out_q.addr;
  assign RDdata_o   = out_q.data;
  assign RS_hit_o   = rd_hit[0];
  assign RSdata_o   = rd_data[0];
  assign RT_hit_o   = rd_hit[1];
  assign RTdata_o   = rd_data[1];
  assign count_o    = count;

endmodule

// File: tb/tb_reg_wb_queue.sv
// tb/tb_reg_wb_queue.sv - scoreboard bench for reg_wb_queue
module tb_reg_wb_queue;
  import reg_wb_queue_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              hold;
  logic              reg_write;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rs_addr, rt_addr;
  logic              rs_hit, rt_hit;
  logic [DATA_W-1:0] rs_data, rt_data;
  logic [2:0]        count;

  int n_cmp = 0;
  int n_err = 0;
  int n_writes = 0;
  wb_entry_t sb[$];

  reg_wb_queue_if wb_if ();

  reg_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk_i     (clk),
    .rst_n     (rst_n),
    .wb        (wb_if),
    .hold_i    (hold),
    .RegWrite_o(reg_write),
    .RDaddr_o  (rd_addr),
    .RDdata_o  (rd_data),
    .RSaddr_i  (rs_addr),
    .RTaddr_i  (rt_addr),
    .RS_hit_o  (rs_hit),
    .RSdata_o  (rs_data),
    .RT_hit_o  (rt_hit),
    .RTdata_o  (rt_data),
    .count_o   (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Register file side: compare each write, then record this cycle's accepted push.
  always @(negedge clk) begin
    wb_entry_t e;
    if (reg_write === 1'b1) begin
      n_writes++;
      if (sb.size() == 0) begin
        check_eq("unexpected_write", 32'(rd_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check_eq("rd_addr", 32'(rd_addr), 32'(e.addr));
        check_eq("rd_data", rd_data, e.data);
      end
    end
    if (!rst_n) begin
      sb.delete();
    end else if (wb_if.wb_valid && wb_if.wb_ready && (wb_if.wb_addr != REG_ZERO)) begin
      e.addr = wb_if.wb_addr;
      e.data = wb_if.wb_data;
      sb.push_back(e);
    end
  end

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit ok = 1'b0;
    wb_if.wb_valid = 1'b1;
    wb_if.wb_addr  = a;
    wb_if.wb_data  = d;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (wb_if.wb_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("push_timeout", 32'(ok), 32'd1);
    @(posedge clk); #1;
    wb_if.wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; hold = 1'b0; rs_addr = '0; rt_addr = '0;
    wb_if.wb_valid = 1'b0; wb_if.wb_addr = '0; wb_if.wb_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_regwrite", 32'(reg_write), 32'd0);
    check_eq("rst_count",    32'(count),     32'd0);
    check_eq("rst_ready",    32'(wb_if.wb_ready), 32'd1);
    check_eq("rst_rdaddr",   32'(rd_addr),   32'd0);
    check_eq("rst_rddata",   rd_data,        32'd0);

    // Single push: bypass while pending, write exactly one cycle later.
    @(posedge clk); #1;
    wb_if.wb_valid = 1'b1; wb_if.wb_addr = 5'd8; wb_if.wb_data = 32'h1234_5678; rs_addr = 5'd8;
    @(negedge clk);
    check_eq("byp_before_enq", 32'(rs_hit), 32'd0);
    @(posedge clk); #1;
    wb_if.wb_valid = 1'b0;
    @(negedge clk);
    check_eq("single_hit",      32'(rs_hit),    32'd1);
    check_eq("single_data",     rs_data,        32'h1234_5678);
    check_eq("single_no_write", 32'(reg_write), 32'd0);
    check_eq("single_count",    32'(count),     32'd1);
    @(negedge clk);
    check_eq("single_write",    32'(reg_write), 32'd1);
    check_eq("single_out_hit",  32'(rs_hit),    32'd1);
    check_eq("single_count0",   32'(count),     32'd0);
    @(negedge clk);
    check_eq("single_done",     32'(reg_write), 32'd0);
    check_eq("single_hit_gone", 32'(rs_hit),    32'd0);

    // Fill under hold, fifth push refused, then drain back to back.
    @(posedge clk); #1;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) push(ADDR_W'(20 + i), 32'hA0 + 32'(i));
    wb_if.wb_valid = 1'b1; wb_if.wb_addr = 5'd25; wb_if.wb_data = 32'hBAD;
    rs_addr = 5'd21; rt_addr = 5'd25;
    @(negedge clk);
    check_eq("full_ready",   32'(wb_if.wb_ready), 32'd0);
    check_eq("full_count",   32'(count),  32'd4);
    check_eq("full_rs_hit",  32'(rs_hit), 32'd1);
    check_eq("full_rs_data", rs_data,     32'hA1);
    check_eq("full_rt_hit",  32'(rt_hit), 32'd0);
    @(posedge clk); #1;
    wb_if.wb_valid = 1'b0; hold = 1'b0;
    @(negedge clk);
    check_eq("full_held", 32'(count), 32'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("drain_burst", 32'(reg_write), 32'd1);
    end
    @(negedge clk);
    check_eq("drain_idle",  32'(reg_write), 32'd0);
    check_eq("drain_count", 32'(count),     32'd0);
    check_eq("drain_ready", 32'(wb_if.wb_ready), 32'd1);

    // Same destination twice: newest value forwarded, writes in order.
    @(posedge clk); #1;
    hold = 1'b1;
    push(5'd9, 32'd1);
    push(5'd9, 32'd2);
    rs_addr = 5'd9; rt_addr = 5'd8;
    @(negedge clk);
    check_eq("dup_hit",    32'(rs_hit), 32'd1);
    check_eq("dup_data",   rs_data,     32'd2);
    check_eq("dup_rt_miss", 32'(rt_hit), 32'd0);
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("dup_q_over_out", rs_data, 32'd2);
    @(negedge clk);
    check_eq("dup_out_hit",  32'(rs_hit), 32'd1);
    check_eq("dup_out_data", rs_data,     32'd2);
    @(negedge clk);
    check_eq("dup_gone", 32'(rs_hit), 32'd0);

    // R0: handshake completes, nothing queued or written.
    @(posedge clk); #1;
    wb_if.wb_valid = 1'b1; wb_if.wb_addr = 5'd0; wb_if.wb_data = 32'hDEAD;
    rs_addr = 5'd0; rt_addr = 5'd0;
    @(negedge clk);
    check_eq("r0_ready", 32'(wb_if.wb_ready), 32'd1);
    @(posedge clk); #1;
    wb_if.wb_valid = 1'b0;
    @(negedge clk);
    check_eq("r0_count",  32'(count),  32'd0);
    check_eq("r0_rs_hit", 32'(rs_hit), 32'd0);
    check_eq("r0_rt_hit", 32'(rt_hit), 32'd0);
    @(negedge clk);
    check_eq("r0_no_write", 32'(reg_write), 32'd0);

    // Streaming: one push and one pop per cycle across pointer wrap.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      wb_if.wb_valid = 1'b1; wb_if.wb_addr = ADDR_W'(10 + i); wb_if.wb_data = $urandom;
      @(negedge clk);
      if (i > 0) check_eq("stream_count", 32'(count), 32'd1);
      if (i > 1) check_eq("stream_write", 32'(reg_write), 32'd1);
    end
    @(posedge clk); #1;
    wb_if.wb_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("stream_empty", 32'(count), 32'd0);

    // Reset with entries pending discards them.
    @(posedge clk); #1;
    hold = 1'b1;
    push(5'd3, 32'h33);
    push(5'd4, 32'h44);
    push(5'd5, 32'h55);
    @(negedge clk);
    check_eq("pre_rst_count", 32'(count), 32'd3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; hold = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_count",    32'(count),     32'd0);
    check_eq("mid_rst_regwrite", 32'(reg_write), 32'd0);
    check_eq("mid_rst_ready",    32'(wb_if.wb_ready), 32'd1);
    repeat (4) @(negedge clk);
    check_eq("mid_rst_silent", 32'(reg_write), 32'd0);

    check_eq("total_writes", 32'(n_writes), 32'd19);
    check_eq("sb_empty",     32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
